// File: rtl/max_pool_2x2_if.sv
// Pixel stream bus into and out of the 2x2 max-pool stage. The upstream producer and the
// downstream consumer use the master side. The pooling block uses the slave side.
interface max_pool_2x2_if;
   logic        input_valid;
   logic        i_sof;
   logic [31:0] data_in;
   logic        output_valid;
   logic [31:0] data_out;
   logic        o_sof;

   modport master (
      output input_valid,
      output i_sof,
      output data_in,
      input  output_valid,
      input  data_out,
      input  o_sof
   );

   modport slave (
      input  input_valid,
      input  i_sof,
      input  data_in,
      output output_valid,
      output data_out,
      output o_sof
   );
endinterface

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max-pool over post-ReLU FP32 pixels in raster order.
// For non-negative IEEE-754 values, unsigned integer order matches float order.
module max_pool_2x2 #(
   parameter int IMG_W = 4,
   parameter int IMG_H = 4
) (
   input  logic           clk,
   input  logic           rst,
   max_pool_2x2_if.slave  bus
);

   localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int PAIRS  = IMG_W / 2;
   localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0]  col_q, col_d, cur_col;
   logic [ROW_W-1:0]  row_q, row_d, cur_row;
   logic [31:0]       held_q, held_d;
   logic [31:0]       linebuf_q [PAIRS];
   logic [31:0]       linebuf_d [PAIRS];
   logic              out_valid_q, out_valid_d;
   logic              out_sof_q, out_sof_d;
   logic [31:0]       out_data_q, out_data_d;

   logic [31:0]       pixel;
   logic [31:0]       hmax;
   logic [31:0]       upper;
   logic [31:0]       vmax;
   logic [PAIR_W-1:0] pair;

   // A start-of-frame pixel restarts the raster position at (0,0).
   // Counter state and stale line-buffer contents are ignored from that point.
   always_comb begin
      pixel   = bus.data_in[31] ? 32'd0 : bus.data_in;
      cur_col = bus.i_sof ? '0 : col_q;
      cur_row = bus.i_sof ? '0 : row_q;
      pair    = PAIR_W'(cur_col >> 1);
      hmax    = (pixel > held_q) ? pixel : held_q;
      upper   = linebuf_q[pair];
      vmax    = (hmax > upper) ? hmax : upper;
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      held_d      = held_q;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_data_d  = out_data_q;
      for (int i = 0; i < PAIRS; i++) begin
         linebuf_d[i] = linebuf_q[i];
      end

      if (bus.input_valid) begin
         if (!cur_col[0]) begin
            held_d = pixel;
         end else if (!cur_row[0]) begin
            linebuf_d[pair] = hmax;
         end else begin
            out_valid_d = 1'b1;
            out_data_d  = vmax;
            out_sof_d   = (cur_row == ROW_W'(1)) && (cur_col == COL_W'(1));
         end

         if (cur_col == LAST_COL) begin
            col_d = '0;
            row_d = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
         end else begin
            col_d = cur_col + COL_W'(1);
            row_d = cur_row;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_q       <= '0;
         row_q       <= '0;
         held_q      <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         held_q      <= held_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_data_q  <= out_data_d;
      end
   end

   // The line buffer is not reset. It is always rewritten on an even row before it is read.
   always_ff @(posedge clk) begin
      linebuf_q <= linebuf_d;
   end

   assign bus.output_valid = out_valid_q;
   assign bus.o_sof        = out_sof_q;
   assign bus.data_out     = out_data_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2. The expected pooled pixels come from a reference
// max over each 2x2 window. They are queued when the window's last pixel is driven.
module tb_max_pool_2x2;

   localparam int IMG_W = 4;
   localparam int IMG_H = 4;
   localparam int NPIX  = IMG_W * IMG_H;

   typedef logic [31:0] frame_t [0:NPIX-1];

   logic clk;
   logic rst;
   max_pool_2x2_if bus ();

   max_pool_2x2 #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors;
   int          miscompares;
   logic [32:0] sb [$];
   logic [32:0] got;
   logic [32:0] want;
   logic        e;

   function automatic logic [31:0] san(input logic [31:0] x);
      return x[31] ? 32'd0 : x;
   endfunction

   function automatic logic [31:0] pool_ref(input frame_t f, input int r, input int c);
      logic [31:0] m;
      m = 32'd0;
      for (int dr = 0; dr < 2; dr++) begin
         for (int dc = 0; dc < 2; dc++) begin
            if (san(f[(r - dr) * IMG_W + (c - dc)]) > m) m = san(f[(r - dr) * IMG_W + (c - dc)]);
         end
      end
      return m;
   endfunction

   task automatic make_random(output frame_t f);
      for (int i = 0; i < NPIX; i++) f[i] = $urandom;
   endtask

   // Drives one cycle. When the window closes, the expected output is queued.
   task automatic drive(input frame_t f, input int idx, input logic v, input logic sof,
                        input logic model, output logic exp_out);
      int r;
      int c;
      r = idx / IMG_W;
      c = idx % IMG_W;
      @(negedge clk);
      bus.input_valid = v;
      bus.i_sof       = v ? sof : 1'($urandom_range(0, 1));
      bus.data_in     = v ? f[idx] : $urandom;
      exp_out = v && model && (r % 2 == 1) && (c % 2 == 1);
      if (exp_out) sb.push_back({(r == 1 && c == 1) ? 1'b1 : 1'b0, pool_ref(f, r, c)});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rst = 1'b0;
         bus.input_valid = 1'($urandom_range(0, 1));
         bus.i_sof       = 1'($urandom_range(0, 1));
         bus.data_in     = $urandom;
         @(posedge clk);
         #1;
         vectors++;
         if ({bus.output_valid, bus.o_sof, bus.data_out} !== 34'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold cyc%0d: valid=%b sof=%b data=%h, want 0 0 00000000",
                     i, bus.output_valid, bus.o_sof, bus.data_out);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      bus.input_valid = 1'b0;
   endtask

   task automatic test_continuous();
      frame_t f;
      f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h00000000, 32'h00000000, 32'h3F000000, 32'h3E800000,
            32'h00000000, 32'h3F000000, 32'h41000000, 32'h00000000};
      for (int i = 0; i < NPIX; i++) begin
         drive(f, i, 1'b1, i == 0, 1'b1, e);
         vectors++;
         if (bus.output_valid !== e) begin
            miscompares++;
            $display("[TB] FAIL cont_timing px%0d: output_valid=%b, want %b", i, bus.output_valid, e);
         end
         if (bus.output_valid === 1'b1 && sb.size() > 0) begin
            got  = {bus.o_sof, bus.data_out};
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL cont_data px%0d: sof/data=%b/%h, want %b/%h", i, got[32], got[31:0], want[32], want[31:0]);
            end
         end
      end
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL cont_count: %0d outputs missing, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_gaps();
      frame_t      f;
      logic [31:0] last;
      logic        seen;
      f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h00000000, 32'h00000000, 32'h3F000000, 32'h3E800000,
            32'h00000000, 32'h3F000000, 32'h41000000, 32'h00000000};
      seen = 1'b0;
      last = 32'd0;
      for (int i = 0; i < 2 * NPIX; i++) begin
         drive(f, i / 2, (i % 2 == 0), (i == 0), 1'b1, e);
         vectors++;
         if (bus.output_valid !== e) begin
            miscompares++;
            $display("[TB] FAIL gap_timing cyc%0d: output_valid=%b, want %b", i, bus.output_valid, e);
         end
         if (bus.output_valid === 1'b1 && sb.size() > 0) begin
            got  = {bus.o_sof, bus.data_out};
            want = sb.pop_front();
            last = want[31:0];
            seen = 1'b1;
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL gap_data cyc%0d: sof/data=%b/%h, want %b/%h", i, got[32], got[31:0], want[32], want[31:0]);
            end
         end else if (seen && bus.output_valid === 1'b0) begin
            vectors++;
            if (bus.data_out !== last) begin
               miscompares++;
               $display("[TB] FAIL gap_hold cyc%0d: data_out=%h, want %h", i, bus.data_out, last);
            end
         end
      end
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL gap_count: %0d outputs missing, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_negative();
      frame_t f;
      for (int i = 0; i < NPIX; i++) f[i] = 32'd0;
      f[0] = 32'hBF800000;
      for (int i = 0; i < NPIX; i++) begin
         drive(f, i, 1'b1, i == 0, 1'b1, e);
         vectors++;
         if (bus.output_valid !== e) begin
            miscompares++;
            $display("[TB] FAIL neg_timing px%0d: output_valid=%b, want %b", i, bus.output_valid, e);
         end
         if (bus.output_valid === 1'b1 && sb.size() > 0) begin
            got  = {bus.o_sof, bus.data_out};
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL neg_data px%0d: sof/data=%b/%h, want %b/%h", i, got[32], got[31:0], want[32], want[31:0]);
            end
         end
      end
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL neg_count: %0d outputs missing, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_resync();
      frame_t a;
      frame_t b;
      make_random(a);
      make_random(b);
      for (int i = 0; i < 5 + NPIX; i++) begin
         if (i < 5) drive(a, i, 1'b1, i == 0, 1'b0, e);
         else       drive(b, i - 5, 1'b1, i == 5, 1'b1, e);
         vectors++;
         if (bus.output_valid !== e) begin
            miscompares++;
            $display("[TB] FAIL resync_timing cyc%0d: output_valid=%b, want %b", i, bus.output_valid, e);
         end
         if (bus.output_valid === 1'b1 && sb.size() > 0) begin
            got  = {bus.o_sof, bus.data_out};
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL resync_data cyc%0d: sof/data=%b/%h, want %b/%h", i, got[32], got[31:0], want[32], want[31:0]);
            end
         end
      end
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL resync_count: %0d outputs missing, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_back_to_back();
      frame_t a;
      frame_t b;
      int     outs;
      make_random(a);
      make_random(b);
      outs = 0;
      for (int i = 0; i < 2 * NPIX; i++) begin
         if (i < NPIX) drive(a, i, 1'b1, i == 0, 1'b1, e);
         else          drive(b, i - NPIX, 1'b1, i == NPIX, 1'b1, e);
         vectors++;
         if (bus.output_valid !== e) begin
            miscompares++;
            $display("[TB] FAIL b2b_timing cyc%0d: output_valid=%b, want %b", i, bus.output_valid, e);
         end
         if (bus.output_valid === 1'b1 && sb.size() > 0) begin
            got  = {bus.o_sof, bus.data_out};
            want = sb.pop_front();
            outs++;
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL b2b_data out%0d: sof/data=%b/%h, want %b/%h", outs, got[32], got[31:0], want[32], want[31:0]);
            end
         end
      end
      vectors++;
      if (outs !== 8 || sb.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: %0d outputs seen, want 8", outs);
         sb.delete();
      end
   endtask

   task automatic test_mid_reset();
      frame_t a;
      frame_t b;
      a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
            32'h00000000, 32'h00000000, 32'h3F000000, 32'h3E800000,
            32'h00000000, 32'h3F000000, 32'h41000000, 32'h00000000};
      make_random(b);
      for (int i = 0; i < 10; i++) begin
         drive(a, i, 1'b1, i == 0, 1'b1, e);
         if (bus.output_valid === 1'b1 && sb.size() > 0) begin
            got  = {bus.o_sof, bus.data_out};
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL mrst_pre px%0d: sof/data=%b/%h, want %b/%h", i, got[32], got[31:0], want[32], want[31:0]);
            end
         end
      end
      @(negedge clk);
      rst = 1'b0;
      bus.input_valid = 1'b1;
      bus.i_sof       = 1'b0;
      bus.data_in     = 32'h7F000000;
      @(posedge clk);
      #1;
      vectors++;
      if ({bus.output_valid, bus.o_sof, bus.data_out} !== 34'd0) begin
         miscompares++;
         $display("[TB] FAIL mrst_clear: valid=%b sof=%b data=%h, want 0 0 00000000",
                  bus.output_valid, bus.o_sof, bus.data_out);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.input_valid = 1'b0;
      for (int i = 0; i < NPIX; i++) begin
         drive(b, i, 1'b1, 1'b0, 1'b1, e);
         vectors++;
         if (bus.output_valid !== e) begin
            miscompares++;
            $display("[TB] FAIL mrst_timing px%0d: output_valid=%b, want %b", i, bus.output_valid, e);
         end
         if (bus.output_valid === 1'b1 && sb.size() > 0) begin
            got  = {bus.o_sof, bus.data_out};
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
               miscompares++;
               $display("[TB] FAIL mrst_data px%0d: sof/data=%b/%h, want %b/%h", i, got[32], got[31:0], want[32], want[31:0]);
            end
         end
      end
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL mrst_count: %0d outputs missing, want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      vectors         = 0;
      miscompares     = 0;
      rst             = 1'b0;
      bus.input_valid = 1'b0;
      bus.i_sof       = 1'b0;
      bus.data_in     = 32'd0;
      test_reset();
      test_continuous();
      test_gaps();
      test_negative();
      test_resync();
      test_back_to_back();
      test_mid_reset();
      @(negedge clk);
      bus.input_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Streaming 2x2 stride-2 max-pool stage directly downstream of the 8-input FP32 adder-tree/ReLU stage.
- Consumes one post-ReLU FP32 activation per valid cycle in raster order, plus start-of-frame.
- Emits the pooled (IMG_W/2) x (IMG_H/2) map with its own valid and start-of-frame.
- Non-negative IEEE-754 values order identically to unsigned 32-bit integers, so comparison is integer magnitude only; no FP comparator is needed.

Parameters:
- IMG_W, 4, input frame width in pixels; must be even and >= 2.
- IMG_H, 4, input frame height in lines; must be even and >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- input_valid  in  1  data_in/i_sof qualify this cycle.
- i_sof  in  1  first pixel of a frame; sampled only when input_valid=1.
- data_in  in  32  FP32 activation.
- output_valid  out  1  data_out/o_sof valid this cycle.
- data_out  out  32  pooled FP32 maximum.
- o_sof  out  1  first pooled pixel of a frame.

Behaviour:
- Reset (rst=0 at a clock edge):
  - output_valid, o_sof and data_out become 0.
  - col/row counters become 0.
  - The held even-column pixel is cleared to 0.
  - Line-buffer contents are don't-care.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (row0, col0).
- Input sanitising: any data_in with bit31=1 is treated as 32'd0 before comparison.
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1.
  - They advance only on input_valid=1.
  - col wraps to 0 and row increments at end of line.
  - row wraps to 0 after the last pixel of the frame.
- i_sof=1 with input_valid=1: that pixel is (row0, col0) regardless of counter state.
  - A partial frame in progress is abandoned and no output is produced for it.
  - Line-buffer entries written before the resync are not reused.
- Horizontal pairing:
  - Even col: pixel is held in a register.
  - Odd col: hmax = max(held, pixel).
- Even row, odd col: hmax is written to line buffer entry col>>1. The buffer has IMG_W/2 x 32 bits.
- Odd row, odd col: result = max(hmax, linebuf[col>>1]).
  - Registered to data_out with output_valid=1 on the next clock edge (latency 1 cycle from the accepting edge).
- o_sof=1 with the output for row1/col1 only; 0 otherwise.
- output_valid is a single-cycle pulse per pooled pixel. It is 0 on every other cycle, including input_valid gaps.
- data_out holds its last value when output_valid=0.
- Output rate: at most one output per 4 accepted inputs. Exactly (IMG_W/2)*(IMG_H/2) outputs per complete frame.
- No backpressure: the consumer must accept every output_valid cycle.
- Ties: equal values yield that value. Max of the four equals the unsigned integer max of the sanitised inputs.
- Back-to-back frames: last pixel of frame N followed immediately by i_sof of frame N+1 needs no bubble.
  - The last output of frame N appears in the same cycle the first pixel of N+1 is accepted.

Test Plan:
- Reset hold → output_valid=0, o_sof=0, data_out=0x00000000 for every cycle while rst=0.
- 4x4 frame, continuous valid:
  - Input row0 = 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000).
  - Input row1 = 4.0, 1.0, 1.0, 1.0.
  - Input row2 = 0, 0, 0.5, 0.25.
  - Input row3 = 0, 0x3F000000 (0.5), 8.0, 0.
  - Expected outputs: 0x40800000 with o_sof=1 (the cycle after pixel r1c1), then 0x40800000, 0x3F000000, 0x41000000.
  - o_sof=0 on outputs 2-4.
- Same frame with input_valid deasserted on alternate cycles → identical 4 output values and order; each output exactly 1 cycle after its r-odd/c-odd pixel is accepted.
- Negative input: one 2x2 window = 0xBF800000, 0, 0, 0 (rest of frame 0) → pooled output 0x00000000.
- Mid-frame resync: i_sof asserted at the 6th pixel of a frame → no output for the abandoned frame; the next 16 pixels produce 4 outputs with o_sof on the first.
- Back-to-back frames and mid-frame reset:
  - Two consecutive frames with no gap → 8 outputs, o_sof on outputs 1 and 5.
  - rst=0 for one cycle during row2 → outputs return to 0; next frame pools correctly.
